// File: rtl/alu_req_arbiter_if.sv
// Bundles the two requester handshakes and the ALU operand/result path of alu_req_arbiter.
// Optional statistics outputs appear only when ALU_ARB_STATS_EN is defined.
interface alu_req_arbiter_if;
  logic        Req0;
  logic [2:0]  Op0;
  logic [31:0] A0;
  logic [31:0] B0;
  logic        Gnt0;
  logic        Done0;

  logic        Req1;
  logic [2:0]  Op1;
  logic [31:0] A1;
  logic [31:0] B1;
  logic        Gnt1;
  logic        Done1;

  logic [31:0] Rsp_Result;
  logic        Rsp_C;
  logic        Rsp_Err;

  logic [31:0] Alu_A;
  logic [31:0] Alu_B;
  logic [2:0]  Alu_Op;
  logic [31:0] Alu_Result;
  logic        Alu_C;
  logic        Alu_We;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] Stat_Ops;
  logic [7:0]  Stat_Timeouts;
`endif

  // The arbiter is the slave; the environment (requesters plus ALU) is the master.
  modport slave (
    input  Req0, Op0, A0, B0, Req1, Op1, A1, B1,
    input  Alu_Result, Alu_C, Alu_We,
    output Gnt0, Done0, Gnt1, Done1,
    output Rsp_Result, Rsp_C, Rsp_Err,
`ifdef ALU_ARB_STATS_EN
    output Stat_Ops, Stat_Timeouts,
`endif
    output Alu_A, Alu_B, Alu_Op
  );

  modport master (
    output Req0, Op0, A0, B0, Req1, Op1, A1, B1,
    output Alu_Result, Alu_C, Alu_We,
    input  Gnt0, Done0, Gnt1, Done1,
    input  Rsp_Result, Rsp_C, Rsp_Err,
`ifdef ALU_ARB_STATS_EN
    input  Stat_Ops, Stat_Timeouts,
`endif
    input  Alu_A, Alu_B, Alu_Op
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin arbiter/sequencer owning the shared ALU's A/B/ALUOp inputs.
// Define ALU_ARB_STATS_EN to add saturating completion/timeout counters.
module alu_req_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic              Clk,
  input logic              Reset,
  alu_req_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        last_q,   last_d;
  logic [15:0] cnt_q,    cnt_d;
  logic [31:0] a_q,      a_d;
  logic [31:0] b_q,      b_d;
  logic [2:0]  op_q,     op_d;
  logic [31:0] result_q, result_d;
  logic        c_q,      c_d;
  logic        err_q,    err_d;

  logic any_req;
  logic win;
  logic complete;
  logic abort;

  assign any_req = bus.Req0 | bus.Req1;
  // On a tie the requester that was not served last wins; otherwise the sole requester.
  assign win      = (bus.Req0 && bus.Req1) ? ~last_q : bus.Req1;
  assign complete = (state_q == S_EXEC) && bus.Alu_We;
  assign abort    = (state_q == S_EXEC) && !bus.Alu_We && (cnt_q == TimeoutLast);

`ifdef ALU_ARB_STATS_EN
  logic [15:0] stat_ops_q, stat_ops_d;
  logic [7:0]  stat_to_q,  stat_to_d;
`endif

  always_ff @(posedge Clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (Reset) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 3'b000;
      result_q <= '0;
      c_q      <= 1'b0;
      err_q    <= 1'b0;
`ifdef ALU_ARB_STATS_EN
      stat_ops_q <= '0;
      stat_to_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      c_q      <= c_d;
      err_q    <= err_d;
`ifdef ALU_ARB_STATS_EN
      stat_ops_q <= stat_ops_d;
      stat_to_q  <= stat_to_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every variable gets a hold default first, so no path can infer a latch.
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    c_d      = c_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          last_d  = win;
          cnt_d   = '0;
          a_d     = win ? bus.A1  : bus.A0;
          b_d     = win ? bus.B1  : bus.B0;
          op_d    = win ? bus.Op1 : bus.Op0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // A valid result takes priority over a timeout expiring in the same cycle.
        if (complete) begin
          result_d = bus.Alu_Result;
          c_d      = bus.Alu_C;
          err_d    = 1'b0;
          state_d  = S_RESP;
        end else if (abort) begin
          result_d = '0;
          c_d      = 1'b0;
          err_d    = 1'b1;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef ALU_ARB_STATS_EN
  always_comb begin
    stat_ops_d = stat_ops_q;
    stat_to_d  = stat_to_q;
    if (complete && (stat_ops_q != '1)) stat_ops_d = stat_ops_q + 16'd1;
    if (abort    && (stat_to_q  != '1)) stat_to_d  = stat_to_q + 8'd1;
  end

  assign bus.Stat_Ops      = stat_ops_q;
  assign bus.Stat_Timeouts = stat_to_q;
`endif

  // The counter is zero only in the first EXEC cycle, which is the grant cycle.
  always_comb begin
    bus.Gnt0       = (state_q == S_EXEC) && (cnt_q == '0) && !last_q;
    bus.Gnt1       = (state_q == S_EXEC) && (cnt_q == '0) &&  last_q;
    bus.Done0      = (state_q == S_RESP) && !last_q;
    bus.Done1      = (state_q == S_RESP) &&  last_q;
    bus.Alu_Op     = (state_q == S_EXEC) ? op_q : 3'b000;
    bus.Alu_A      = a_q;
    bus.Alu_B      = b_q;
    bus.Rsp_Result = result_q;
    bus.Rsp_C      = c_q;
    bus.Rsp_Err    = err_q;
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a behavioural ALU (MOD takes four EXEC cycles).
// Stat counter checks are compiled in when ALU_ARB_STATS_EN is defined.
module tb_alu_req_arbiter;

  logic clk;
  logic rst;
  logic alu_stuck;
  logic [3:0]  mod_cnt;
  logic [32:0] sum;

  int vectors;
  int misses;
  int exec_cycles;
  int n_gnt;
  int order [4];
  logic outstanding;

  alu_req_arbiter_if bus ();

  alu_req_arbiter #(.TIMEOUT(8)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The modulo result becomes valid on the fourth consecutive cycle Alu_Op is 3'b111.
  always_ff @(posedge clk) begin
    if (rst || bus.Alu_Op != 3'b111) mod_cnt <= '0;
    else if (mod_cnt != 4'hf)         mod_cnt <= mod_cnt + 4'd1;
  end

  always_comb begin
    sum            = '0;
    bus.Alu_C      = 1'b0;
    bus.Alu_Result = '0;
    case (bus.Alu_Op)
      3'b000: bus.Alu_Result = bus.Alu_A & bus.Alu_B;
      3'b001: bus.Alu_Result = bus.Alu_A | bus.Alu_B;
      3'b010: bus.Alu_Result = bus.Alu_A ^ bus.Alu_B;
      3'b011: bus.Alu_Result = ~(bus.Alu_A | bus.Alu_B);
      3'b100: bus.Alu_Result = {31'd0, $signed(bus.Alu_A) < $signed(bus.Alu_B)};
      3'b101: begin
        sum = {1'b0, bus.Alu_A} + {1'b0, bus.Alu_B};
        bus.Alu_Result = sum[31:0];
        bus.Alu_C      = sum[32];
      end
      3'b110: begin
        sum = {1'b0, bus.Alu_A} + {1'b0, ~bus.Alu_B} + 33'd1;
        bus.Alu_Result = sum[31:0];
        bus.Alu_C      = sum[32];
      end
      default: bus.Alu_Result = (bus.Alu_B == 0) ? 32'd0 : bus.Alu_A % bus.Alu_B;
    endcase
    bus.Alu_We = !alu_stuck && ((bus.Alu_Op != 3'b111) || (mod_cnt >= 4'd3));
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misses++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors = 0;
    misses  = 0;
    alu_stuck = 1'b0;
    bus.Req0 = 1'b0; bus.Op0 = '0; bus.A0 = '0; bus.B0 = '0;
    bus.Req1 = 1'b0; bus.Op1 = '0; bus.A1 = '0; bus.B1 = '0;
    rst = 1'b1;
    tick();
    tick();
    check("rst_gnt0",   bus.Gnt0, 0);
    check("rst_gnt1",   bus.Gnt1, 0);
    check("rst_done0",  bus.Done0, 0);
    check("rst_done1",  bus.Done1, 0);
    check("rst_result", bus.Rsp_Result, 0);
    check("rst_c",      bus.Rsp_C, 0);
    check("rst_err",    bus.Rsp_Err, 0);
    check("rst_alu_a",  bus.Alu_A, 0);
    check("rst_alu_b",  bus.Alu_B, 0);
    check("rst_alu_op", bus.Alu_Op, 0);
    rst = 1'b0;

    // ADD 5 + 7 from requester 0
    bus.Req0 = 1'b1; bus.Op0 = 3'b101; bus.A0 = 32'd5; bus.B0 = 32'd7;
    tick();
    check("add_gnt0",   bus.Gnt0, 1);
    check("add_gnt1",   bus.Gnt1, 0);
    check("add_alu_op", bus.Alu_Op, 3'b101);
    check("add_alu_a",  bus.Alu_A, 5);
    bus.Req0 = 1'b0;
    tick();
    check("add_done0",  bus.Done0, 1);
    check("add_done1",  bus.Done1, 0);
    check("add_gnt0_off", bus.Gnt0, 0);
    check("add_result", bus.Rsp_Result, 12);
    check("add_c",      bus.Rsp_C, 0);
    check("add_err",    bus.Rsp_Err, 0);
    check("add_op_resp", bus.Alu_Op, 0);
    tick();
    check("add_done0_off", bus.Done0, 0);

    // SUB 7 - 5 from requester 1
    bus.Req1 = 1'b1; bus.Op1 = 3'b110; bus.A1 = 32'd7; bus.B1 = 32'd5;
    tick();
    check("sub_gnt1", bus.Gnt1, 1);
    check("sub_gnt0", bus.Gnt0, 0);
    bus.Req1 = 1'b0;
    tick();
    check("sub_done1",   bus.Done1, 1);
    check("sub_done0",   bus.Done0, 0);
    check("sub_result",  bus.Rsp_Result, 2);
    check("sub_c",       bus.Rsp_C, 1);
    check("sub_op_resp", bus.Alu_Op, 0);
    tick();
    check("sub_op_idle", bus.Alu_Op, 0);

    // Tie from reset: requester 0 ADD 2+3, requester 1 OR 8|3, two rounds
    rst = 1'b1;
    bus.Req0 = 1'b1; bus.Op0 = 3'b101; bus.A0 = 32'd2; bus.B0 = 32'd3;
    bus.Req1 = 1'b1; bus.Op1 = 3'b001; bus.A1 = 32'd8; bus.B1 = 32'd3;
    tick();
    rst = 1'b0;
    n_gnt = 0;
    outstanding = 1'b0;
    for (int r = 0; r < 2; r++) begin
      bus.Req0 = 1'b1;
      bus.Req1 = 1'b1;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (bus.Gnt0 || bus.Gnt1) begin
          check("tie_no_overlap", bus.Gnt0 & bus.Gnt1, 0);
          check("tie_gnt_after_done", outstanding, 0);
          if (n_gnt < 4) order[n_gnt] = bus.Gnt1 ? 1 : 0;
          n_gnt++;
          outstanding = 1'b1;
          if (bus.Gnt0) bus.Req0 = 1'b0;
          if (bus.Gnt1) bus.Req1 = 1'b0;
        end
        if (bus.Done0) begin
          check("tie_result0", bus.Rsp_Result, 5);
          outstanding = 1'b0;
        end
        if (bus.Done1) begin
          check("tie_result1", bus.Rsp_Result, 11);
          outstanding = 1'b0;
        end
      end
    end
    check("tie_gnt_count", n_gnt, 4);
    check("tie_order0", order[0], 0);
    check("tie_order1", order[1], 1);
    check("tie_order2", order[2], 0);
    check("tie_order3", order[3], 1);

    // Multi-cycle MOD 17 % 5 holds operands until We
    bus.Req0 = 1'b1; bus.Op0 = 3'b111; bus.A0 = 32'd17; bus.B0 = 32'd5;
    tick();
    check("mod_gnt0", bus.Gnt0, 1);
    bus.Req0 = 1'b0;
    exec_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.Done0) break;
      exec_cycles++;
      check("mod_op_held", bus.Alu_Op, 3'b111);
      check("mod_a_held",  bus.Alu_A, 17);
      tick();
    end
    check("mod_exec_cycles", exec_cycles, 4);
    check("mod_done0",  bus.Done0, 1);
    check("mod_result", bus.Rsp_Result, 2);
    check("mod_err",    bus.Rsp_Err, 0);
    tick();

    // Timeout: We stuck low, TIMEOUT = 8
    alu_stuck = 1'b1;
    bus.Req0 = 1'b1; bus.Op0 = 3'b111; bus.A0 = 32'd9; bus.B0 = 32'd4;
    tick();
    check("to_gnt0", bus.Gnt0, 1);
    bus.Req0 = 1'b0;
    exec_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.Done0) break;
      exec_cycles++;
      tick();
    end
    check("to_exec_cycles", exec_cycles, 8);
    check("to_done0",  bus.Done0, 1);
    check("to_err",    bus.Rsp_Err, 1);
    check("to_result", bus.Rsp_Result, 0);
    check("to_c",      bus.Rsp_C, 0);
`ifdef ALU_ARB_STATS_EN
    check("to_stat_timeouts", bus.Stat_Timeouts, 1);
    check("to_stat_ops",      bus.Stat_Ops, 5);
`endif
    alu_stuck = 1'b0;
    tick();

    // Normal op after a timeout: ADD 100 + 23 from requester 1
    bus.Req1 = 1'b1; bus.Op1 = 3'b101; bus.A1 = 32'd100; bus.B1 = 32'd23;
    tick();
    check("post_to_gnt1", bus.Gnt1, 1);
    bus.Req1 = 1'b0;
    tick();
    check("post_to_done1",  bus.Done1, 1);
    check("post_to_result", bus.Rsp_Result, 123);
    check("post_to_err",    bus.Rsp_Err, 0);
`ifdef ALU_ARB_STATS_EN
    check("post_to_stat_ops", bus.Stat_Ops, 6);
`endif
    tick();

    // Reset in the middle of a MOD EXEC
    bus.Req0 = 1'b1; bus.Op0 = 3'b111; bus.A0 = 32'd17; bus.B0 = 32'd5;
    tick();
    check("mid_gnt0", bus.Gnt0, 1);
    bus.Req0 = 1'b0;
    tick();
    check("mid_op_exec", bus.Alu_Op, 3'b111);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_gnt0",   bus.Gnt0, 0);
    check("mid_rst_done0",  bus.Done0, 0);
    check("mid_rst_op",     bus.Alu_Op, 0);
    check("mid_rst_a",      bus.Alu_A, 0);
    check("mid_rst_b",      bus.Alu_B, 0);
    check("mid_rst_result", bus.Rsp_Result, 0);
    check("mid_rst_err",    bus.Rsp_Err, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("mid_no_done", bus.Done0 | bus.Done1, 0);
    end
    bus.Req0 = 1'b1; bus.Op0 = 3'b101; bus.A0 = 32'd1; bus.B0 = 32'd1;
    tick();
    check("mid_add_gnt0", bus.Gnt0, 1);
    bus.Req0 = 1'b0;
    tick();
    check("mid_add_done0",  bus.Done0, 1);
    check("mid_add_result", bus.Rsp_Result, 2);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
